// File: rtl/draw_scheduler.sv
// Round-robin arbiter and sequencer for the shared sprite drawer.
// Up to three requesters post draw/erase commands; the winner's command is
// latched and held on the drawer inputs for a fixed per-sprite plot window,
// after which a one-cycle done pulse is returned to that requester.
module draw_scheduler #(
  parameter int GARB_CYCLES  = 402,
  parameter int PRESS_CYCLES = 2402,
  parameter int CNT_W        = 12
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [2:0] req,
  input  logic [2:0] req_item,
  input  logic [2:0] req_erase,
  input  logic [5:0] req_pos,
  output logic [2:0] grant,
  output logic [2:0] done,
  output logic       item,
  output logic       erase,
  output logic [1:0] position,
  output logic       draw_go,
  output logic       busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Window lengths are loaded as length-1 so the BUSY state lasts exactly
  // the window: the cycle that sees cnt==0 is the last draw_go cycle.
  localparam logic [CNT_W-1:0] GARB_LOAD  = CNT_W'(GARB_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rr_last_q, rr_last_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       done_q, done_d;
  logic             item_q, item_d;
  logic             erase_q, erase_d;
  logic [1:0]       pos_q, pos_d;
  logic             draw_go_q, draw_go_d;
  logic             busy_q, busy_d;

  logic [1:0] cand0, cand1, cand2;
  logic [1:0] win;

  // Pick the winner: first requesting index after the last winner, mod 3.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    cand0 = 2'd0;
    cand1 = 2'd1;
    cand2 = 2'd2;
    case (rr_last_q)
      2'd0: begin cand0 = 2'd1; cand1 = 2'd2; cand2 = 2'd0; end
      2'd1: begin cand0 = 2'd2; cand1 = 2'd0; cand2 = 2'd1; end
      default: begin cand0 = 2'd0; cand1 = 2'd1; cand2 = 2'd2; end
    endcase
    if (req[cand0])      win = cand0;
    else if (req[cand1]) win = cand1;
    else                 win = cand2;
  end

  // Sequencer next-state: IDLE -> BUSY (window) -> DONE -> IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_last_d = rr_last_q;
    grant_d   = 3'b000;
    done_d    = 3'b000;
    item_d    = item_q;
    erase_d   = erase_q;
    pos_d     = pos_q;
    draw_go_d = draw_go_q;
    busy_d    = busy_q;
    case (state_q)
      S_IDLE: begin
        draw_go_d = 1'b0;
        if (|req) begin
          item_d    = req_item[win];
          erase_d   = req_erase[win];
          pos_d     = req_pos[{win, 1'b0} +: 2];
          cnt_d     = req_item[win] ? PRESS_LOAD : GARB_LOAD;
          grant_d   = 3'b001 << win;
          draw_go_d = 1'b1;
          busy_d    = 1'b1;
          rr_last_d = win;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          done_d    = 3'b001 << rr_last_q;
          draw_go_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        draw_go_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and registered outputs; synchronous active-low reset aborts any window.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rr_last_q <= 2'd2;
      grant_q   <= 3'b000;
      done_q    <= 3'b000;
      item_q    <= 1'b0;
      erase_q   <= 1'b1;
      pos_q     <= 2'd0;
      draw_go_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_last_q <= rr_last_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      item_q    <= item_d;
      erase_q   <= erase_d;
      pos_q     <= pos_d;
      draw_go_q <= draw_go_d;
      busy_q    <= busy_d;
    end
  end

  assign grant    = grant_q;
  assign done     = done_q;
  assign item     = item_q;
  assign erase    = erase_q;
  assign position = pos_q;
  assign draw_go  = draw_go_q;
  assign busy     = busy_q;

endmodule
